fifo_stream_checker: RTL and testbench



---
 rtl/fifo_stream_checker_pkg.sv | 20 ++
 rtl/stall_watchdog.sv | 50 +++++
 rtl/fifo_stream_checker.sv | 209 ++++++++++++++++++++
 tb/tb_fifo_stream_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_checker_pkg.sv
// Shared types and default sizing for the FIFO read-side stream checker.
package fifo_stream_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned FSC_DATA_WIDTH     = 32;
    localparam int unsigned FSC_CNT_WIDTH      = 16;
    localparam int unsigned FSC_TIMEOUT_CYCLES = 1024;

    // All-ones value a CNT_WIDTH counter saturates at.
    function automatic logic [63:0] cnt_sat_value(input int unsigned width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stall ticks; EXPIRE fires on the tick that reaches TIMEOUT_CYCLES.
module stall_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLEAR,
    input  logic TICK,
    output logic EXPIRE
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_s;
            assign unused_s = ^{CLK, RST, CLEAR, TICK};
            assign EXPIRE   = 1'b0;
        end else begin : g_on
            localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
            localparam logic [W-1:0] ONE  = W'(1);

            logic [W-1:0] stall_q;
            logic [W-1:0] stall_d;

            // Next stall count: clear wins over tick.
            always_comb begin
                stall_d = stall_q;
                if (CLEAR) begin
                    stall_d = '0;
                end else if (TICK) begin
                    stall_d = stall_q + ONE;
                end else begin
                    stall_d = stall_q;
                end
            end

            // Stall count register.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    stall_q <= '0;
                end else begin
                    stall_q <= stall_d;
                end
            end

            assign EXPIRE = TICK && (stall_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/fifo_stream_checker.sv
// Drains a show-ahead FIFO in bursts/gaps and checks for an incrementing sequence from SEED.
module fifo_stream_checker
    import fifo_stream_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = FSC_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH      = FSC_CNT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = FSC_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] SEED,
    input  logic [CNT_WIDTH-1:0]  BURST_LEN,
    input  logic [CNT_WIDTH-1:0]  GAP_LEN,
    input  logic [CNT_WIDTH-1:0]  TOTAL,
    output logic                  R_nEN,
    input  logic [DATA_WIDTH-1:0] R_DATA,
    input  logic                  R_EMPTY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  TIMEOUT,
    output logic [CNT_WIDTH-1:0]  RX_COUNT,
    output logic [CNT_WIDTH-1:0]  ERR_COUNT,
    output logic [CNT_WIDTH-1:0]  FIRST_ERR_IDX,
    output logic [DATA_WIDTH-1:0] FIRST_ERR_DATA
);

    localparam logic [CNT_WIDTH-1:0]  CNT_SAT  = CNT_WIDTH'(cnt_sat_value(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  burst_len_q, burst_len_d;
    logic [CNT_WIDTH-1:0]  gap_len_q, gap_len_d;
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [CNT_WIDTH-1:0]  rx_q, rx_d;
    logic [CNT_WIDTH-1:0]  err_q, err_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] edata_q, edata_d;
    logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CNT_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  r_nen_q, r_nen_d;

    logic                  pop_s;
    logic                  expire_s;
    logic                  wd_clear_s;
    logic                  wd_tick_s;
    logic [CNT_WIDTH-1:0]  rx_inc_s;
    logic [CNT_WIDTH-1:0]  burst_inc_s;
    logic [CNT_WIDTH-1:0]  gap_inc_s;

    // R_nEN is low exactly in BURST, so a pop depends on state and R_EMPTY only.
    assign pop_s       = (state_q == ST_BURST) && !R_EMPTY;
    assign rx_inc_s    = rx_q + CNT_ONE;
    assign burst_inc_s = burst_cnt_q + CNT_ONE;
    assign gap_inc_s   = gap_cnt_q + CNT_ONE;
    assign wd_tick_s   = (state_q == ST_BURST) && R_EMPTY;
    assign wd_clear_s  = pop_s || (state_d != state_q);

    stall_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_watchdog (
        .CLK    (CLK),
        .RST    (RST),
        .CLEAR  (wd_clear_s),
        .TICK   (wd_tick_s),
        .EXPIRE (expire_s)
    );

    // Next-state, compare and counter logic.
    always_comb begin
        state_d     = state_q;
        burst_len_d = burst_len_q;
        gap_len_d   = gap_len_q;
        total_d     = total_q;
        exp_d       = exp_q;
        rx_d        = rx_q;
        err_d       = err_q;
        idx_d       = idx_q;
        edata_d     = edata_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    burst_len_d = BURST_LEN;
                    gap_len_d   = GAP_LEN;
                    total_d     = TOTAL;
                    exp_d       = SEED;
                    rx_d        = '0;
                    err_d       = '0;
                    idx_d       = '0;
                    edata_d     = '0;
                    burst_cnt_d = '0;
                    gap_cnt_d   = '0;
                    timeout_d   = 1'b0;
                    state_d     = (TOTAL == '0) ? ST_DONE : ST_BURST;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BURST: begin
                if (pop_s) begin
                    if (R_DATA != exp_q) begin
                        if (err_q != CNT_SAT) begin
                            err_d = err_q + CNT_ONE;
                        end else begin
                            err_d = err_q;
                        end
                        if (err_q == '0) begin
                            idx_d   = rx_q;
                            edata_d = R_DATA;
                        end else begin
                            idx_d   = idx_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    // Expected value free-runs; it never resyncs to received data.
                    exp_d       = exp_q + DATA_ONE;
                    rx_d        = rx_inc_s;
                    burst_cnt_d = burst_inc_s;
                    if (rx_inc_s == total_q) begin
                        state_d = ST_DONE;
                    end else if ((burst_len_q != '0) && (burst_inc_s == burst_len_q)) begin
                        burst_cnt_d = '0;
                        gap_cnt_d   = '0;
                        state_d     = (gap_len_q != '0) ? ST_GAP : ST_BURST;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else if (expire_s) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_GAP: begin
                if (gap_inc_s == gap_len_q) begin
                    gap_cnt_d = '0;
                    state_d   = ST_BURST;
                end else begin
                    gap_cnt_d = gap_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d == ST_BURST) || (state_d == ST_GAP);
        done_d  = (state_d == ST_DONE);
        r_nen_d = (state_d != ST_BURST);
    end

    // State, configuration and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            burst_len_q <= '0;
            gap_len_q   <= '0;
            total_q     <= '0;
            exp_q       <= '0;
            rx_q        <= '0;
            err_q       <= '0;
            idx_q       <= '0;
            edata_q     <= '0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            r_nen_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            burst_len_q <= burst_len_d;
            gap_len_q   <= gap_len_d;
            total_q     <= total_d;
            exp_q       <= exp_d;
            rx_q        <= rx_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            edata_q     <= edata_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            r_nen_q     <= r_nen_d;
        end
    end

    assign R_nEN          = r_nen_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign TIMEOUT        = timeout_q;
    assign RX_COUNT       = rx_q;
    assign ERR_COUNT      = err_q;
    assign FIRST_ERR_IDX  = idx_q;
    assign FIRST_ERR_DATA = edata_q;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Bench for fifo_stream_checker: queue-based show-ahead FIFO model plus a run-result scoreboard.
module tb_fifo_stream_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] seed;
    logic [15:0] burst_len, gap_len, total;
    logic        r_nen;
    logic [31:0] r_data;
    logic        r_empty;
    logic        busy, done, timeout;
    logic [15:0] rx, errc, fidx;
    logic [31:0] fdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        done;
        logic        timeout;
        logic [15:0] rx;
        logic [15:0] err;
        logic [15:0] idx;
        logic [31:0] data;
    } res_t;

    logic [31:0] fifo_q[$];
    res_t        sb_q[$];

    always #5 clk = ~clk;

    fifo_stream_checker #(
        .DATA_WIDTH     (32),
        .CNT_WIDTH      (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .START          (start),
        .SEED           (seed),
        .BURST_LEN      (burst_len),
        .GAP_LEN        (gap_len),
        .TOTAL          (total),
        .R_nEN          (r_nen),
        .R_DATA         (r_data),
        .R_EMPTY        (r_empty),
        .BUSY           (busy),
        .DONE           (done),
        .TIMEOUT        (timeout),
        .RX_COUNT       (rx),
        .ERR_COUNT      (errc),
        .FIRST_ERR_IDX  (fidx),
        .FIRST_ERR_DATA (fdata)
    );

    task automatic fifo_sync();
        r_empty = (fifo_q.size() == 0);
        r_data  = r_empty ? 32'd0 : fifo_q[0];
    endtask

    // FIFO model: a pop happens at the edge where R_nEN=0 and the FIFO is non-empty.
    always @(posedge clk) begin
        if (!r_nen && !r_empty) begin
            #1;
            void'(fifo_q.pop_front());
            fifo_sync();
        end
    end

    function automatic res_t observed();
        return {done, timeout, rx, errc, fidx, fdata};
    endfunction

    task automatic start_run(input logic [31:0] s, input logic [15:0] bl,
                             input logic [15:0] gl, input logic [15:0] tot);
        seed = s; burst_len = bl; gap_len = gl; total = tot;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_wait: DONE=%b expected 1 within 200 cycles", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({r_nen, busy, done, timeout, rx, errc, fidx, fdata} !== {1'b1, 3'b000, 48'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset: nEN=%b busy=%b done=%b to=%b rx=%0d err=%0d idx=%0d data=%h expected 1 0 0 0 0 0 0 0",
                     r_nen, busy, done, timeout, rx, errc, fidx, fdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        logic [11:0] pat;
        res_t exp_r;
        fifo_q.delete();
        for (int i = 0; i < 20; i++) fifo_q.push_back(32'd5 + 32'(i));
        fifo_sync();
        sb_q.push_back('{done: 1'b1, timeout: 1'b0, rx: 16'd8, err: 16'd0, idx: 16'd0, data: 32'd0});
        start_run(32'd5, 16'd0, 16'd0, 16'd8);
        for (int k = 0; k < 12; k++) begin
            pat[k] = r_nen;
            @(negedge clk);
        end
        checks++;
        if (pat !== 12'hF00) begin
            errors++;
            $display("FAIL continuous_nen_pattern: got %b expected %b", pat, 12'hF00);
        end
        wait_done("continuous");
        exp_r = sb_q.pop_front();
        checks++;
        if (observed() !== exp_r || busy !== 1'b0) begin
            errors++;
            $display("FAIL continuous_result: got %h busy=%b expected %h busy=0", observed(), busy, exp_r);
        end
        checks++;
        if (fifo_q.size() !== 12) begin
            errors++;
            $display("FAIL continuous_pops: words left %0d expected 12", fifo_q.size());
        end
    endtask

    task automatic test_burst_gap();
        logic [13:0] pat;
        res_t exp_r;
        fifo_q.delete();
        for (int i = 0; i < 20; i++) fifo_q.push_back(32'd100 + 32'(i));
        fifo_sync();
        sb_q.push_back('{done: 1'b1, timeout: 1'b0, rx: 16'd7, err: 16'd0, idx: 16'd0, data: 32'd0});
        start_run(32'd100, 16'd3, 16'd2, 16'd7);
        for (int k = 0; k < 14; k++) begin
            pat[k] = r_nen;
            @(negedge clk);
        end
        // Sample k=0 first: 000 11 000 11 0 then high.
        checks++;
        if (pat !== 14'b11101100011000) begin
            errors++;
            $display("FAIL burst_gap_nen_pattern: got %b expected %b", pat, 14'b11101100011000);
        end
        wait_done("burst_gap");
        exp_r = sb_q.pop_front();
        checks++;
        if (observed() !== exp_r) begin
            errors++;
            $display("FAIL burst_gap_result: got %h expected %h", observed(), exp_r);
        end
        checks++;
        if (fifo_q.size() !== 13) begin
            errors++;
            $display("FAIL burst_gap_pops: words left %0d expected 13", fifo_q.size());
        end
    endtask

    task automatic test_mismatch();
        res_t exp_r;
        fifo_q = '{32'd0, 32'd1, 32'd2, 32'd9, 32'd4, 32'd5};
        fifo_sync();
        sb_q.push_back('{done: 1'b1, timeout: 1'b0, rx: 16'd6, err: 16'd1, idx: 16'd3, data: 32'd9});
        start_run(32'd0, 16'd0, 16'd0, 16'd6);
        wait_done("mismatch");
        exp_r = sb_q.pop_front();
        checks++;
        if (observed() !== exp_r) begin
            errors++;
            $display("FAIL mismatch_result: got %h expected %h", observed(), exp_r);
        end
    endtask

    task automatic test_wrap();
        res_t exp_r;
        fifo_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        fifo_sync();
        sb_q.push_back('{done: 1'b1, timeout: 1'b0, rx: 16'd4, err: 16'd0, idx: 16'd0, data: 32'd0});
        start_run(32'hFFFF_FFFE, 16'd0, 16'd0, 16'd4);
        wait_done("wrap");
        exp_r = sb_q.pop_front();
        checks++;
        if (observed() !== exp_r) begin
            errors++;
            $display("FAIL wrap_result: got %h expected %h", observed(), exp_r);
        end
    endtask

    task automatic test_timeout();
        res_t exp_r;
        int   stalls = 0;
        fifo_q = '{32'd0, 32'd1};
        fifo_sync();
        sb_q.push_back('{done: 1'b1, timeout: 1'b1, rx: 16'd2, err: 16'd0, idx: 16'd0, data: 32'd0});
        start_run(32'd0, 16'd0, 16'd0, 16'd10);
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            if (!r_nen && r_empty) stalls++;
            @(negedge clk);
        end
        checks++;
        if (stalls !== 16) begin
            errors++;
            $display("FAIL timeout_stall_cycles: got %0d expected 16", stalls);
        end
        wait_done("timeout");
        exp_r = sb_q.pop_front();
        checks++;
        if (observed() !== exp_r || busy !== 1'b0 || r_nen !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: got %h busy=%b nEN=%b expected %h busy=0 nEN=1",
                     observed(), busy, r_nen, exp_r);
        end
    endtask

    task automatic test_busy_start_and_reset();
        logic [15:0] rx_a;
        res_t exp_r;
        int   left;
        fifo_q.delete();
        for (int i = 0; i < 60; i++) fifo_q.push_back(32'(i));
        fifo_sync();
        start_run(32'd0, 16'd0, 16'd0, 16'd50);
        repeat (3) @(negedge clk);
        rx_a = rx;
        start_run(32'd999, 16'd4, 16'd3, 16'd2);
        checks++;
        if (rx !== rx_a + 16'd1 || busy !== 1'b1 || r_nen !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy: rx=%0d busy=%b nEN=%b expected rx=%0d busy=1 nEN=0",
                     rx, busy, r_nen, rx_a + 16'd1);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (errc !== 16'd0 || rx !== rx_a + 16'd5 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_config_kept: err=%0d rx=%0d done=%b expected err=0 rx=%0d done=0",
                     errc, rx, done, rx_a + 16'd5);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({r_nen, busy, done, timeout, rx, errc, fidx, fdata} !== {1'b1, 3'b000, 48'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_run: nEN=%b busy=%b done=%b rx=%0d err=%0d expected 1 0 0 0 0",
                     r_nen, busy, done, rx, errc);
        end
        left = fifo_q.size();
        sb_q.push_back('{done: 1'b1, timeout: 1'b0, rx: 16'd0, err: 16'd0, idx: 16'd0, data: 32'd0});
        start_run(32'd0, 16'd0, 16'd0, 16'd0);
        exp_r = sb_q.pop_front();
        checks++;
        if (observed() !== exp_r || busy !== 1'b0 || r_nen !== 1'b1) begin
            errors++;
            $display("FAIL total_zero: got %h busy=%b nEN=%b expected %h busy=0 nEN=1",
                     observed(), busy, r_nen, exp_r);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_q.size() !== left || r_nen !== 1'b1) begin
            errors++;
            $display("FAIL total_zero_no_pop: words left %0d nEN=%b expected %0d nEN=1",
                     fifo_q.size(), r_nen, left);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; seed = 32'd0;
        burst_len = 16'd0; gap_len = 16'd0; total = 16'd0;
        fifo_sync();
        @(negedge clk);
        test_reset();
        test_continuous();
        test_burst_gap();
        test_mismatch();
        test_wrap();
        test_timeout();
        test_busy_start_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
